// File: rtl/seq_player.sv
// seq_player: plays the stored Genius sequence on the LEDs.
// Steps the sequence ROM address from 0 up to the latched level. Each colour
// is lit for ON_CYCLES, followed by OFF_CYCLES of darkness. A one-cycle done
// pulse then hands control to the player-input stage.
module seq_player #(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000,
  parameter int CNT_W      = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] level,
  input  logic [3:0] rom_data,
  output logic [3:0] rom_addr,
  output logic [3:0] led,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, step, latched level and timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      last_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start latches the level, abort beats timer expiry.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d  = level;
          step_d  = 4'd0;
          cnt_d   = '0;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (abort) begin
          state_d = ST_IDLE;
          step_d  = 4'd0;
          cnt_d   = '0;
        end else if (cnt_q == ON_LAST) begin
          cnt_d   = '0;
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_OFF: begin
        if (abort) begin
          state_d = ST_IDLE;
          step_d  = 4'd0;
          cnt_d   = '0;
        end else if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          if (step_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = ST_ON;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        step_d  = 4'd0;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 4'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode directly from the registered state so reset clears them at once.
  always_comb begin
    rom_addr = step_q;
    led      = (state_q == ST_ON) ? rom_data : 4'b0000;
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: directed scenarios for seq_player with a small sequence ROM.
module tb_seq_player;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] level;
  logic [3:0] rom_data;
  logic [3:0] rom_addr;
  logic [3:0] led;
  logic       busy;
  logic       done;

  int tests_run;
  int tests_failed;

  logic [3:0] rom [16];

  seq_player #(
    .ON_CYCLES (3),
    .OFF_CYCLES(2),
    .CNT_W     (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .level   (level),
    .rom_data(rom_data),
    .rom_addr(rom_addr),
    .led     (led),
    .busy    (busy),
    .done    (done)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational sequence ROM model.
  always_comb rom_data = rom[rom_addr];

  // Hard time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to the next cycle and settle just after the active edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    level = 4'd0;
    #2;
    tests_run++;
    if ({led, rom_addr, busy, done} !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got led=%b addr=%0d busy=%b done=%b, want all 0",
               led, rom_addr, busy, done);
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_level2(input int start_again_cycle);
    logic [3:0] exp_led [15] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    level = 4'd2;
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      start = (c == start_again_cycle) ? 1'b1 : 1'b0;
      if (c <= 15) begin
        tests_run++;
        if (led !== exp_led[c-1]) begin
          tests_failed++;
          $display("[TB] FAIL level2_led c=%0d: got %b, want %b", c, led, exp_led[c-1]);
        end
      end
      tests_run++;
      if (done !== (c == 16)) begin
        tests_failed++;
        $display("[TB] FAIL level2_done c=%0d: got %b, want %b", c, done, (c == 16));
      end
      tests_run++;
      if (busy !== (c <= 16)) begin
        tests_failed++;
        $display("[TB] FAIL level2_busy c=%0d: got %b, want %b", c, busy, (c <= 16));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_level15;
    int k;
    int ph;
    logic [3:0] exp;
    level = 4'd15;
    start = 1'b1;
    for (int c = 1; c <= 82; c++) begin
      next_cycle();
      start = 1'b0;
      if (c <= 80) begin
        k   = (c - 1) / 5;
        ph  = (c - 1) % 5;
        exp = (ph < 3) ? rom[k] : 4'b0000;
        tests_run++;
        if (rom_addr !== 4'(k)) begin
          tests_failed++;
          $display("[TB] FAIL level15_addr c=%0d: got %0d, want %0d", c, rom_addr, k);
        end
        tests_run++;
        if (led !== exp) begin
          tests_failed++;
          $display("[TB] FAIL level15_led c=%0d: got %b, want %b", c, led, exp);
        end
      end
      if (c == 78) begin
        tests_run++;
        if (led !== 4'b0010) begin
          tests_failed++;
          $display("[TB] FAIL level15_last_colour: got %b, want 0010", led);
        end
      end
      tests_run++;
      if (done !== (c == 81)) begin
        tests_failed++;
        $display("[TB] FAIL level15_done c=%0d: got %b, want %b", c, done, (c == 81));
      end
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL level15_idle: got busy=%b, want 0", busy);
    end
  endtask

  task automatic test_level_change;
    logic [3:0] exp;
    level = 4'd0;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      start = 1'b0;
      if (c == 2) level = 4'd7;
      exp = (c <= 3) ? 4'b0001 : 4'b0000;
      tests_run++;
      if (led !== exp) begin
        tests_failed++;
        $display("[TB] FAIL lvlchg_led c=%0d: got %b, want %b", c, led, exp);
      end
      tests_run++;
      if (done !== (c == 6)) begin
        tests_failed++;
        $display("[TB] FAIL lvlchg_done c=%0d: got %b, want %b", c, done, (c == 6));
      end
      tests_run++;
      if (busy !== (c <= 6)) begin
        tests_failed++;
        $display("[TB] FAIL lvlchg_busy c=%0d: got %b, want %b", c, busy, (c <= 6));
      end
    end
  endtask

  task automatic test_abort;
    level = 4'd3;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      start = 1'b0;
      abort = (c == 9) ? 1'b1 : 1'b0;
      tests_run++;
      if (done !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL abort_done c=%0d: got %b, want 0", c, done);
      end
      if (c == 9) begin
        tests_run++;
        if (busy !== 1'b1 || led !== 4'b0000 || rom_addr !== 4'd1) begin
          tests_failed++;
          $display("[TB] FAIL abort_in_off: got busy=%b led=%b addr=%0d, want 1 0000 1",
                   busy, led, rom_addr);
        end
      end
      if (c >= 10) begin
        tests_run++;
        if (busy !== 1'b0 || led !== 4'b0000 || rom_addr !== 4'd0) begin
          tests_failed++;
          $display("[TB] FAIL abort_idle c=%0d: got busy=%b led=%b addr=%0d, want 0 0000 0",
                   c, busy, led, rom_addr);
        end
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_async_reset;
    level = 4'd2;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      start = 1'b0;
    end
    tests_run++;
    if (rom_addr !== 4'd1 || led !== 4'b0100 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rst_pre: got addr=%0d led=%b busy=%b, want 1 0100 1",
               rom_addr, led, busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({led, rom_addr, busy, done} !== 10'd0) begin
      tests_failed++;
      $display("[TB] FAIL rst_async: got led=%b addr=%0d busy=%b done=%b, want all 0",
               led, rom_addr, busy, done);
    end
    next_cycle();
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      tests_run++;
      if (busy !== 1'b0 || led !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL rst_stay_idle c=%0d: got busy=%b led=%b, want 0 0000", c, busy, led);
      end
    end
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      next_cycle();
      start = 1'b0;
      if (c == 1) begin
        tests_run++;
        if (led !== 4'b0001 || busy !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL rst_restart: got led=%b busy=%b, want 0001 1", led, busy);
        end
      end
      if (c == 16) begin
        tests_run++;
        if (done !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL rst_restart_done: got %b, want 1", done);
        end
      end
    end
  endtask

  // Scenarios run back to back, each leaving the player idle.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rom = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b0010};
    test_reset();
    test_level2(0);
    next_cycle();
    test_level15();
    next_cycle();
    test_level_change();
    next_cycle();
    test_abort();
    next_cycle();
    test_level2(4);
    next_cycle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_player.md
# seq_player

Playback stage for the Genius game that drives the sequence ROM (`SEQ2`) and consumes its one-hot colour output. On a start request it steps the ROM address from 0 up to the current level, lights each colour on the LEDs for a fixed on-time, and separates colours with a dark gap. It pulses `done` when the last gap ends, which hands control to the player-input stage.

## Interface

- `ON_CYCLES`, default 25000000: cycles each colour is lit (0.5 s at 50 MHz); must be ≥1.
- `OFF_CYCLES`, default 12500000: dark cycles after each colour; must be ≥1.
- `CNT_W`, default 25: timer width; must hold max(ON_CYCLES, OFF_CYCLES)−1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  playback request; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; sampled in ON/OFF.
- `level`  in  4  index of the last step to play; plays level+1 steps (1..16).
- `rom_data`  in  4  one-hot colour from the sequence ROM for `rom_addr`.
- `rom_addr`  out  4  registered step index fed to the sequence ROM.
- `led`  out  4  colour shown; `rom_data` in ON, 4'b0000 otherwise.
- `busy`  out  1  high in ON, OFF and DONE.
- `done`  out  1  one-cycle pulse in DONE.

## Operation

- Registers: `state` (IDLE, ON, OFF, DONE), `step` (4 b, drives `rom_addr`), `last_q` (4 b), `cnt` (CNT_W b).
- Reset (asynchronous, immediate): state=IDLE, step=0, last_q=0, cnt=0. Outputs follow at once: `rom_addr`=0, `led`=0, `busy`=0, `done`=0.
- IDLE: `start`=1 latches `last_q`←`level`, sets `step`←0 and `cnt`←0, then goes to ON. Otherwise the block stays in IDLE.
- ON: `led`=`rom_data` (combinational pass-through, no one-hot check; 4'b0000 shows as a dark step).
  - `cnt` increments each cycle.
  - When `cnt`=ON_CYCLES−1: `cnt`←0 and the block goes to OFF.
- OFF: `led`=0; `cnt` increments.
  - When `cnt`=OFF_CYCLES−1 and `step`=`last_q`: go to DONE.
  - When `cnt`=OFF_CYCLES−1 and `step`≠`last_q`: `step`←`step`+1, `cnt`←0, go to ON.
- DONE: `done`=1 for exactly one cycle, then go to IDLE with `step`←0.
- `abort`=1 in ON or OFF: next state is IDLE, `step`←0, `cnt`←0, and no `done` pulse. `abort` has priority over timer expiry in the same cycle. It is ignored in IDLE and DONE.
- `start` is ignored outside IDLE. Changes to `level` after the start cycle are ignored.
- `step` never wraps: the maximum is 15 when `last_q`=15.

## Timing

- `start` is sampled high in cycle 0. ON occupies cycles 1..ON_CYCLES; OFF follows for OFF_CYCLES cycles.
- With N=`last_q`+1 steps and P=ON_CYCLES+OFF_CYCLES:
  - step k (0-based) is lit in cycles k·P+1 .. k·P+ON_CYCLES;
  - `done` is high in cycle N·P+1;
  - IDLE resumes in cycle N·P+2, and the earliest next start is accepted there.
- `rom_addr` changes on the edge that enters ON, so `rom_data` is valid for the whole ON window (the ROM is combinational).
- If `start` is held high continuously, playback restarts from the IDLE cycle that follows DONE.

## Test plan

The bench uses ON_CYCLES=3, OFF_CYCLES=2 and `SEQ2` as the ROM.

- Reset, then `start` with `level`=2. Required `led` trace from cycle 1: 0001×3, 0000×2, 0100×3, 0000×2, 0010×3, 0000×2. `done`=1 only in cycle 16; `busy`=1 in cycles 1..16.
- `level`=15. `rom_addr` runs 0..15 with no wrap, and the final lit colour is 0010. `done` is high in cycle 81; IDLE resumes in cycle 82.
- `start` at `level`=0, with `level` changed to 7 in cycle 2. Exactly one step (0001) is played and `done` is high in cycle 6.
- `abort` asserted in cycle 9 (OFF of step 1, `level`=3). IDLE is entered in cycle 10 with `led`=0, `rom_addr`=0 and `busy`=0; `done` is never asserted.
- `start` pulsed in cycle 4 during playback. It has no effect and the trace matches scenario 1.
- `rst_n` dropped mid-ON of step 1. `led`, `rom_addr`, `busy` and `done` are 0 immediately, before the next edge; after release the block sits in IDLE until `start`.
